// File: rtl/ysyx_22041412_mem_arbiter.sv
// Two-master memory arbiter: instruction fetch (IF) and load/store (MEM)
// share one downstream RAM port with at most one transaction in flight.
// MEM has priority, but IF is forced through after STARVE_MAX consecutive
// MEM wins while it waits. A pipeline flush discards an owned fetch response
// while still letting the downstream transaction run to completion.
module ysyx_22041412_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [63:0] mem_rdata,
    output logic        ram_valid,
    input  logic        ram_ready,
    output logic        ram_wen,
    output logic [63:0] ram_addr,
    output logic [63:0] ram_wdata,
    output logic [7:0]  ram_wmask,
    input  logic        ram_rvalid,
    input  logic [63:0] ram_rdata,
    output logic        arb_busy
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic             pick_if;
    logic             pick_mem;
    logic             owner_if;
    logic             drop;
    logic             if_gnt_r;
    logic             mem_gnt_r;
    logic [CNT_W-1:0] starve_cnt;

    logic             lat_wen;
    logic [63:0]      lat_addr;
    logic [63:0]      lat_wdata;
    logic [7:0]       lat_wmask;
    logic [63:0]      rdata_buf;

    // Saturating increment of the IF starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_MAX) begin
            return CNT_MAX;
        end
        return cnt + 1'b1;
    endfunction

    // Next state and arbitration decision; a winner is only ever picked in IDLE.
    always_comb begin
        state_next = state;
        pick_if    = 1'b0;
        pick_mem   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && (!mem_req || starve_cnt == CNT_MAX)) begin
                    pick_if = 1'b1;
                end else if (mem_req) begin
                    pick_mem = 1'b1;
                end
                if (pick_if || pick_mem) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   if (ram_ready)  state_next = WAIT;
            WAIT:    if (ram_rvalid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control: grant pulses, owner, starvation counter and fetch drop flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_gnt_r   <= 1'b0;
            mem_gnt_r  <= 1'b0;
            owner_if   <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_gnt_r  <= pick_if;
            mem_gnt_r <= pick_mem;
            if (state == IDLE) begin
                drop <= 1'b0;
                if (pick_if || pick_mem) begin
                    owner_if <= pick_if;
                end
                if (!if_req || pick_if) begin
                    starve_cnt <= '0;
                end else if (pick_mem) begin
                    starve_cnt <= sat_inc(starve_cnt);
                end
            end else if (owner_if && if_flush) begin
                drop <= 1'b1;
            end
        end
    end

    // Datapath: winner's payload latched on the grant edge, read data captured in WAIT.
    always_ff @(posedge clk) begin
        if (pick_if) begin
            lat_wen   <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_wmask <= '0;
        end else if (pick_mem) begin
            lat_wen   <= mem_wen;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_wmask <= mem_wmask;
        end
        if (state == WAIT && ram_rvalid) begin
            rdata_buf <= ram_rdata;
        end
    end

    assign arb_busy  = (state != IDLE);
    assign ram_valid = (state == ISSUE);
    assign ram_wen   = ram_valid & lat_wen;
    assign ram_addr  = ram_valid ? lat_addr  : '0;
    assign ram_wdata = ram_valid ? lat_wdata : '0;
    assign ram_wmask = ram_valid ? lat_wmask : '0;

    assign if_gnt  = if_gnt_r;
    assign mem_gnt = mem_gnt_r;

    // A flush in the response cycle itself also discards the fetch data.
    assign if_rvalid  = (state == RESP) && owner_if && !drop && !if_flush;
    assign mem_rvalid = (state == RESP) && !owner_if;
    assign if_rdata   = if_rvalid ? rdata_buf : '0;
    assign mem_rdata  = (mem_rvalid && !lat_wen) ? rdata_buf : '0;

endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
// Bench for ysyx_22041412_mem_arbiter: directed cycle table, a starvation
// sequence, and randomized traffic against a transaction-level model.
module tb_ysyx_22041412_mem_arbiter;

    localparam int          SMAX  = 4;
    localparam logic [63:0] IF_A  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_A = 64'h0000_0000_8000_1000;
    localparam logic [63:0] MEM_D = 64'h0000_0000_DEAD_BEEF;
    localparam logic [7:0]  MEM_M = 8'h0F;
    localparam logic [63:0] RD    = 64'h0000_0013_0000_0093;
    localparam logic [63:0] RX    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] RD2   = 64'hCAFE_F00D_0000_0001;

    logic        clk, rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        ram_valid, ram_ready, ram_wen, ram_rvalid;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;
    logic [7:0]  ram_wmask;
    logic        arb_busy;

    ysyx_22041412_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata), .arb_busy(arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ireq, mreq, fl, rdy, rv;
        logic [63:0] rd;
        logic        chk;
        logic [5:0]  ctrl;   // {if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_valid, arb_busy}
        logic [63:0] ird, mrd;
        int          pay;    // 0 none, 1 fetch payload, 2 store payload
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   order_q[$];
    int   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // transaction-level reference model state
    bit          m_open, m_owner_if, m_acc, m_back, m_drop, m_gi, m_gm;
    bit          win_if, resp, e_irv, e_mrv, saw_ig, saw_mg;
    int          m_rv_due, streak;
    logic        m_wen;
    logic [63:0] m_addr, m_wdata, m_data;
    logic [7:0]  m_wmask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, ireq, mreq, fl, rdy, rv, input logic [63:0] rd,
                                input logic c, input logic [5:0] ctl,
                                input logic [63:0] ird, mrd, input int pay);
        vec_t v;
        v.rst = r; v.ireq = ireq; v.mreq = mreq; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.chk = c; v.ctrl = ctl; v.ird = ird; v.mrd = mrd; v.pay = pay;
        return v;
    endfunction

    task automatic check_pay(input string tag, input int pay);
        if (pay == 1) begin
            check({tag, " addr"},  ram_addr, IF_A);
            check({tag, " wdata"}, ram_wdata, 64'd0);
            check({tag, " wen/mask"}, 64'({ram_wen, ram_wmask}), 64'd0);
        end else begin
            check({tag, " addr"},  ram_addr, MEM_A);
            check({tag, " wdata"}, ram_wdata, MEM_D);
            check({tag, " wen/mask"}, 64'({ram_wen, ram_wmask}), 64'({1'b1, MEM_M}));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;
        ram_ready = 1'b0; ram_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; mem_req = 1'b0;
        ram_ready = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
        if_addr = IF_A; mem_wen = 1'b1; mem_addr = MEM_A; mem_wdata = MEM_D; mem_wmask = MEM_M;

        //                 rst ireq mreq fl rdy rv rdata   chk ctrl       ird  mrd  pay
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'd0, 0, 6'b000000, 0,   0,   0)); // 0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 1 reset state
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 2 IF decision
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 64'd0, 1, 6'b100011, 0,   0,   1)); // 3 gnt+issue
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, RD,    1, 6'b000001, 0,   0,   0)); // 4 wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b001001, RD,  0,   0)); // 5 if_rvalid
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 6 store decision
        tbl.push_back(mk(1, 1'b0, 1, 0, 0, 0, 64'd0, 1, 6'b010011, 0, 0,  2)); // 7 ready low
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000011, 0,   0,   2)); // 8 ready low
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000011, 0,   0,   2)); // 9 ready low
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 64'd0, 1, 6'b000011, 0,   0,   2)); // 10 accept
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, RX,    1, 6'b000001, 0,   0,   0)); // 11 wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000101, 0,   0,   0)); // 12 store done, rdata 0
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 13 IF decision
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 64'd0, 1, 6'b100011, 0,   0,   1)); // 14 gnt+issue
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 64'd0, 1, 6'b000001, 0,   0,   0)); // 15 flush in wait
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, RD,    1, 6'b000001, 0,   0,   0)); // 16 ram resp
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'd0, 1, 6'b000001, 0,   0,   0)); // 17 response dropped
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 18 MEM decision
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 64'd0, 1, 6'b010011, 0,   0,   2)); // 19 mem gnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000001, 0,   0,   0)); // 20 wait
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000001, 0,   0,   0)); // 21 reset in wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, RD,    1, 6'b000000, 0,   0,   0)); // 22 late rvalid ignored
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 23 IF decision
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 64'd0, 1, 6'b100011, 0,   0,   1)); // 24 gnt+issue
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, RD2,   1, 6'b000001, 0,   0,   0)); // 25 wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b001001, RD2, 0,   0)); // 26 if_rvalid
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 27 store decision
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 64'd0, 1, 6'b010011, 0,   0,   2)); // 28 reset in issue
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 29 valid dropped
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 64'd0, 1, 6'b000000, 0,   0,   0)); // 30 idle

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; if_req = tbl[i].ireq; mem_req = tbl[i].mreq; if_flush = tbl[i].fl;
            ram_ready = tbl[i].rdy; ram_rvalid = tbl[i].rv; ram_rdata = tbl[i].rd;
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d ctrl", i),
                      64'({if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_valid, arb_busy}),
                      64'(tbl[i].ctrl));
                check($sformatf("vec%0d if_rdata", i), if_rdata, tbl[i].ird);
                check($sformatf("vec%0d mem_rdata", i), mem_rdata, tbl[i].mrd);
                if (tbl[i].pay != 0) check_pay($sformatf("vec%0d", i), tbl[i].pay);
            end
        end

        // both masters requesting every cycle: IF forced through after SMAX MEM wins
        do_reset();
        if_req = 1'b1; mem_req = 1'b1; mem_wen = 1'b0; if_flush = 1'b0;
        ram_ready = 1'b1; ram_rvalid = 1'b1; ram_rdata = RD;
        for (int c = 0; c < 44; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("starve%0d excl", c), 64'(if_gnt & mem_gnt), 64'd0);
            if (if_gnt) order_q.push_back(1);
            else if (mem_gnt) order_q.push_back(0);
        end
        check("starve grant count", 64'(order_q.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < order_q.size(); i++)
            check($sformatf("starve order%0d", i), 64'(order_q[i]), 64'(exp_order[i]));

        // randomized traffic against the transaction-level model
        do_reset();
        m_open = 0; m_gi = 0; m_gm = 0; streak = 0; saw_ig = 0; saw_mg = 0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            if (saw_ig) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1; if_addr = {$urandom, $urandom};
            end
            if (saw_mg) mem_req = 1'b0;
            if (!mem_req && $urandom_range(0, 2) != 0) begin
                mem_req = 1'b1; mem_wen = 1'($urandom_range(0, 1));
                mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom};
                mem_wmask = 8'($urandom);
            end
            if_flush  = ($urandom_range(0, 7) == 0);
            ram_ready = 1'($urandom_range(0, 1));
            ram_rdata = {$urandom, $urandom};
            if (m_open && m_acc && !m_back) ram_rvalid = (t == m_rv_due);
            else if (m_open && m_acc)       ram_rvalid = 1'b0;
            else                            ram_rvalid = ($urandom_range(0, 5) == 0);

            @(negedge clk);
            resp  = m_open && m_back;
            e_irv = resp && m_owner_if && !m_drop && !if_flush;
            e_mrv = resp && !m_owner_if;
            check($sformatf("rnd%0d ctrl", t),
                  64'({if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_valid, arb_busy}),
                  64'({m_gi, m_gm, e_irv, e_mrv, m_open && !m_acc, m_open}));
            check($sformatf("rnd%0d if_rdata", t), if_rdata, e_irv ? m_data : 64'd0);
            check($sformatf("rnd%0d mem_rdata", t), mem_rdata, (e_mrv && !m_wen) ? m_data : 64'd0);
            if (m_open && !m_acc) begin
                check($sformatf("rnd%0d ram_addr", t), ram_addr, m_addr);
                check($sformatf("rnd%0d ram_wdata", t), ram_wdata, m_wdata);
                check($sformatf("rnd%0d ram_wen/mask", t), 64'({ram_wen, ram_wmask}), 64'({m_wen, m_wmask}));
            end
            saw_ig = if_gnt; saw_mg = mem_gnt;

            // model advances across the rising edge that ends this cycle
            m_gi = 0; m_gm = 0;
            if (!m_open) begin
                if (if_req || mem_req) begin
                    win_if = if_req && (!mem_req || streak == SMAX);
                    if (win_if || !if_req) streak = 0;
                    else if (streak < SMAX) streak++;
                    m_open = 1; m_owner_if = win_if; m_acc = 0; m_back = 0; m_drop = 0;
                    m_gi = win_if; m_gm = !win_if;
                    if (win_if) begin
                        m_wen = 1'b0; m_addr = if_addr; m_wdata = '0; m_wmask = '0;
                    end else begin
                        m_wen = mem_wen; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
                    end
                end else begin
                    streak = 0;
                end
            end else begin
                if (if_flush && m_owner_if) m_drop = 1;
                if (!m_acc) begin
                    if (ram_ready) begin
                        m_acc = 1;
                        m_rv_due = t + 1 + int'($urandom_range(0, 2));
                    end
                end else if (!m_back) begin
                    if (ram_rvalid) begin
                        m_back = 1; m_data = ram_rdata;
                    end
                end else begin
                    m_open = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
